// File: rtl/data_sram_pkg.sv
// Shared constants, select encoding and byte-merge helper
// for the data-SRAM responder.
package data_sram_pkg;

  localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;

  localparam logic [15:0] LED_OFF    = 16'hF000;
  localparam logic [15:0] SWITCH_OFF = 16'hF004;
  localparam logic [15:0] TIMER_OFF  = 16'hE000;
  localparam logic [15:0] NUM_OFF    = 16'hF010;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_TIMER,
    SEL_NUM
  } sel_e;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_w,
    input logic [31:0] wdata,
    input logic [3:0]  wen
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = wen[i] ? wdata[8*i +: 8]
                           : old_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_byte_ram.sv
// Byte-writable word RAM, synchronous registered read,
// read-old-data on a same-cycle read/write collision.
module sram_byte_ram
  import data_sram_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clk_i,
  input  logic                  re_i,
  input  logic [3:0]            wen_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem [2**DEPTH_LOG2];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_q <= mem[idx_i];
    if (|wen_i) begin
      mem[idx_i] <= byte_merge(mem[idx_i], wdata_i, wen_i);
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word RAM plus LED/switch/timer/
// display MMIO window, 1-cycle registered read data.
module data_sram_responder
  import data_sram_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 16,
  parameter logic [15:0] MMIO_HI    = MMIO_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  sel_e        sel, sel_d, sel_q;
  logic        is_wr, rd, wr;
  logic [13:0] off;
  logic [31:0] mrd_d, mrd_q;
  logic [15:0] led_d, led_q;
  logic [31:0] led_m;
  logic [31:0] num_d, num_q;
  logic [31:0] timer_d, timer_q;
  logic [31:0] ram_rdata;
  logic        ram_re;
  logic [3:0]  ram_wen;
  logic        unused_ok;

  assign off   = data_sram_addr[15:2];
  assign is_wr = |data_sram_wen;
  assign rd    = data_sram_en & ~is_wr;
  assign wr    = data_sram_en & is_wr;
  assign led_m = byte_merge({16'h0, led_q},
                            data_sram_wdata,
                            data_sram_wen);

  always_comb begin
    sel = SEL_NONE;
    if (data_sram_addr[31:16] != MMIO_HI) begin
      sel = SEL_RAM;
    end else begin
      unique case (1'b1)
        off == LED_OFF[15:2]:    sel = SEL_LED;
        off == SWITCH_OFF[15:2]: sel = SEL_SW;
        off == TIMER_OFF[15:2]:  sel = SEL_TIMER;
        off == NUM_OFF[15:2]:    sel = SEL_NUM;
        default:                 sel = SEL_NONE;
      endcase
    end
  end

  // Reset blocks RAM writes too, since the array itself is not reset.
  assign ram_re  = rd & (sel == SEL_RAM) & ~reset;
  assign ram_wen = (wr & (sel == SEL_RAM) & ~reset)
                 ? data_sram_wen : 4'b0000;

  sram_byte_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk_i  (clk),
    .re_i   (ram_re),
    .wen_i  (ram_wen),
    .idx_i  (data_sram_addr[DEPTH_LOG2+1:2]),
    .wdata_i(data_sram_wdata),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    led_d   = led_q;
    num_d   = num_q;
    timer_d = timer_q + 32'd1;
    sel_d   = sel_q;
    mrd_d   = mrd_q;
    if (wr) begin
      unique case (sel)
        SEL_LED:   led_d   = led_m[15:0];
        SEL_TIMER: timer_d = byte_merge(timer_q,
                               data_sram_wdata,
                               data_sram_wen);
        SEL_NUM:   num_d   = byte_merge(num_q,
                               data_sram_wdata,
                               data_sram_wen);
        default: ;
      endcase
    end
    if (rd) begin
      sel_d = sel;
      unique case (sel)
        SEL_LED:   mrd_d = {16'h0, led_q};
        SEL_SW:    mrd_d = {24'h0, switch};
        SEL_TIMER: mrd_d = timer_q;
        SEL_NUM:   mrd_d = num_q;
        default:   mrd_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q   <= SEL_NONE;
      mrd_q   <= 32'h0;
      led_q   <= 16'h0;
      num_q   <= 32'h0;
      timer_q <= 32'h0;
    end else begin
      sel_q   <= sel_d;
      mrd_q   <= mrd_d;
      led_q   <= led_d;
      num_q   <= num_d;
      timer_q <= timer_d;
    end
  end

  assign data_sram_rdata = (sel_q == SEL_RAM) ? ram_rdata : mrd_q;
  assign led             = led_q;
  assign num_data        = num_q;
  assign unused_ok       = ^{data_sram_addr[1:0], led_m[31:16]};

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: RAM, aliasing,
// MMIO registers, timer wrap and reset behaviour.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic [31:0] num;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] A_LED = 32'hBFAFF000;
  localparam logic [31:0] A_SW  = 32'hBFAFF004;
  localparam logic [31:0] A_TMR = 32'hBFAFE000;
  localparam logic [31:0] A_NUM = 32'hBFAFF010;

  data_sram_responder dut (
    .clk            (clk),
    .reset          (reset),
    .data_sram_en   (en),
    .data_sram_wen  (wen),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(rdata),
    .switch         (sw),
    .led            (led),
    .num_data       (num)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic e, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    sw    = 8'h00;
    drv(1'b0, 4'h0, 32'h0, 32'h0);
    tick(); tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_num", num, 32'h0);
    reset = 1'b0;

    drv(1'b1, 4'hF, A_NUM, 32'h12345678); tick();
    drv(1'b1, 4'hF, A_LED, 32'h0000ABCD); tick();
    drv(1'b1, 4'h0, A_NUM, 32'h0);        tick();
    chk("pre_num_rd", rdata, 32'h12345678);
    chk("pre_led", {16'h0, led}, 32'h0000ABCD);

    drv(1'b1, 4'hF, A_LED, 32'h00005555);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_led", {16'h0, led}, 32'h0);
    chk("mid_rst_num", num, 32'h0);
    tick();
    reset = 1'b0;
    drv(1'b1, 4'h0, A_TMR, 32'h0); tick();
    chk("post_rst_timer", rdata, 32'h0);
    chk("rst_write_dropped", {16'h0, led}, 32'h0);

    drv(1'b1, 4'hF, 32'h100, 32'h11223344); tick();
    chk("hold_on_write", rdata, 32'h0);
    drv(1'b1, 4'h0, 32'h100, 32'h0); tick();
    chk("ram_full", rdata, 32'h11223344);
    drv(1'b1, 4'b0101, 32'h100, 32'hAABBCCDD); tick();
    drv(1'b1, 4'h0, 32'h100, 32'h0); tick();
    chk("ram_partial", rdata, 32'h11BB33DD);
    drv(1'b1, 4'hF, 32'h104, 32'h01020304); tick();
    drv(1'b1, 4'h0, 32'h104, 32'h0); tick();
    chk("ram_next_word", rdata, 32'h01020304);
    drv(1'b1, 4'h0, 32'h100 + (32'd4 << 16), 32'h0); tick();
    chk("ram_alias", rdata, 32'h11BB33DD);

    drv(1'b1, 4'hF, A_LED, 32'hFFFF1234); tick();
    chk("led_write", {16'h0, led}, 32'h00001234);
    sw = 8'hA5;
    drv(1'b1, 4'h0, A_SW, 32'h0); tick();
    chk("switch_rd", rdata, 32'h000000A5);
    drv(1'b1, 4'hF, A_SW, 32'hFFFFFFFF); tick();
    chk("sw_wr_hold", rdata, 32'h000000A5);
    drv(1'b1, 4'h0, A_SW, 32'h0); tick();
    chk("switch_ro", rdata, 32'h000000A5);
    drv(1'b1, 4'h0, 32'hBFAF0008, 32'h0); tick();
    chk("unmapped_rd", rdata, 32'h0);
    drv(1'b1, 4'h0, A_LED, 32'h0); tick();
    chk("led_rd", rdata, 32'h00001234);

    drv(1'b1, 4'hF, A_TMR, 32'hFFFFFFFE); tick();
    drv(1'b1, 4'h0, A_TMR, 32'h0); tick();
    chk("timer_load", rdata, 32'hFFFFFFFE);
    tick();
    chk("timer_inc", rdata, 32'hFFFFFFFF);
    tick();
    chk("timer_wrap", rdata, 32'h0);

    drv(1'b1, 4'hF, A_NUM, 32'hDEADBEEF); tick();
    chk("num_write", num, 32'hDEADBEEF);
    drv(1'b1, 4'h0, A_NUM, 32'h0); tick();
    chk("num_rd", rdata, 32'hDEADBEEF);
    drv(1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_hold", rdata, 32'hDEADBEEF);
    end
    chk("num_held", num, 32'hDEADBEEF);

    drv(1'b1, 4'b0001, A_NUM, 32'h000000AA); tick();
    chk("num_partial", num, 32'hDEADBEAA);
    drv(1'b0, 4'hF, A_NUM, 32'h0); tick();
    chk("en0_ignored", num, 32'hDEADBEAA);
    drv(1'b0, 4'hF, 32'h100, 32'h0); tick();
    drv(1'b1, 4'h0, 32'h100, 32'h0); tick();
    chk("en0_ram_ignored", rdata, 32'h11BB33DD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
